// File: rtl/pipe_stall_ctrl_if.sv
// Hazard inputs and stage enable/clear outputs shared by the pipeline and
// the stall sequencer. The slave modport is the sequencer's view.
interface pipe_stall_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       de_rs1;
  logic [4:0]       de_rs2;
  logic [4:0]       ex_rd;
  logic             ex_dmrd;
  logic             ex_br_taken;
  logic             ex_md_start;
  logic             md_done;
  logic             me_dm_req;
  logic             dm_ready;
  logic             pc_enable;
  logic             fd_enable;
  logic             fd_clr;
  logic             de_enable;
  logic             de_clr;
  logic             em_enable;
  logic             em_clr;
  logic             mw_clr;
  logic             md_timeout;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output de_rs1, de_rs2, ex_rd, ex_dmrd, ex_br_taken, ex_md_start,
           md_done, me_dm_req, dm_ready,
    input  pc_enable, fd_enable, fd_clr, de_enable, de_clr, em_enable,
           em_clr, mw_clr, md_timeout, stall_cycles
  );

  modport slave (
    input  de_rs1, de_rs2, ex_rd, ex_dmrd, ex_br_taken, ex_md_start,
           md_done, me_dm_req, dm_ready,
    output pc_enable, fd_enable, fd_clr, de_enable, de_clr, em_enable,
           em_clr, mw_clr, md_timeout, stall_cycles
  );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory freeze, mul/div wait,
// taken-branch flush and load-use bubble, plus a saturating stall counter.
module pipe_stall_ctrl #(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  pipe_stall_ctrl_if.slave  bus
);

  localparam int             MC_W    = $clog2(MD_TIMEOUT);
  localparam logic [MC_W-1:0] MC_LAST = MC_W'(MD_TIMEOUT - 1);

  typedef enum logic {S_RUN, S_MD_WAIT} state_t;

  state_t            r_state, w_state_nxt;
  logic [MC_W-1:0]   r_md_cnt, w_md_cnt_nxt;
  logic              r_md_done_q, w_md_done_q_nxt;
  logic              r_md_timeout, w_set_timeout;
  logic [CNT_W-1:0]  r_stall_cycles;

  logic w_freeze, w_load_use;
  logic w_pc_en, w_fd_en, w_fd_clr, w_de_en, w_de_clr, w_em_en, w_em_clr, w_mw_clr;

  assign w_freeze   = bus.me_dm_req & ~bus.dm_ready;
  assign w_load_use = bus.ex_dmrd && (bus.ex_rd != 5'd0) &&
                      ((bus.ex_rd == bus.de_rs1) || (bus.ex_rd == bus.de_rs2));

  always_comb begin
    w_state_nxt     = r_state;
    w_md_cnt_nxt    = r_md_cnt;
    w_md_done_q_nxt = r_md_done_q;
    w_set_timeout   = 1'b0;
    w_pc_en  = 1'b1;  w_fd_en  = 1'b1;  w_de_en  = 1'b1;  w_em_en = 1'b1;
    w_fd_clr = 1'b0;  w_de_clr = 1'b0;  w_em_clr = 1'b0;  w_mw_clr = 1'b0;

    if (w_freeze) begin
      // Whole front of the pipe holds; a done pulse must not be lost meanwhile.
      w_pc_en = 1'b0;  w_fd_en = 1'b0;  w_de_en = 1'b0;  w_em_en = 1'b0;
      w_mw_clr        = 1'b1;
      w_md_done_q_nxt = r_md_done_q | bus.md_done;
    end else if (r_state == S_MD_WAIT) begin
      if (bus.md_done || r_md_done_q || (r_md_cnt == MC_LAST)) begin
        w_set_timeout   = ~(bus.md_done | r_md_done_q);
        w_state_nxt     = S_RUN;
        w_md_cnt_nxt    = '0;
        w_md_done_q_nxt = 1'b0;
      end else begin
        w_pc_en = 1'b0;  w_fd_en = 1'b0;  w_de_en = 1'b0;
        w_em_clr     = 1'b1;
        w_md_cnt_nxt = r_md_cnt + 1'b1;
      end
    end else if (bus.ex_md_start) begin
      w_pc_en = 1'b0;  w_fd_en = 1'b0;  w_de_en = 1'b0;
      w_em_clr     = 1'b1;
      w_state_nxt  = S_MD_WAIT;
      w_md_cnt_nxt = MC_W'(1);
    end else if (bus.ex_br_taken) begin
      // Wrong-path ID instruction is flushed, so load-use is moot here.
      w_fd_clr = 1'b1;
      w_de_clr = 1'b1;
    end else if (w_load_use) begin
      w_pc_en  = 1'b0;
      w_fd_en  = 1'b0;
      w_de_clr = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_RUN;
      r_md_cnt       <= '0;
      r_md_done_q    <= 1'b0;
      r_md_timeout   <= 1'b0;
      r_stall_cycles <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_md_cnt    <= w_md_cnt_nxt;
      r_md_done_q <= w_md_done_q_nxt;
      if (w_set_timeout) r_md_timeout <= 1'b1;
      if (!w_pc_en && (r_stall_cycles != {CNT_W{1'b1}}))
        r_stall_cycles <= r_stall_cycles + 1'b1;
    end
  end

  // Reset forces a pass-through pipeline regardless of hazard inputs.
  assign bus.pc_enable    = w_pc_en  | ~rst_n;
  assign bus.fd_enable    = w_fd_en  | ~rst_n;
  assign bus.de_enable    = w_de_en  | ~rst_n;
  assign bus.em_enable    = w_em_en  | ~rst_n;
  assign bus.fd_clr       = w_fd_clr & rst_n;
  assign bus.de_clr       = w_de_clr & rst_n;
  assign bus.em_clr       = w_em_clr & rst_n;
  assign bus.mw_clr       = w_mw_clr & rst_n;
  assign bus.md_timeout   = r_md_timeout;
  assign bus.stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed test-plan sequences followed by random traffic, all checked
// cycle by cycle against an outcome-based reference model.
module tb_pipe_stall_ctrl;
  localparam int MDT = 8;
  localparam int CW  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_stall_ctrl_if #(.CNT_W(CW)) bus();
  pipe_stall_ctrl #(.MD_TIMEOUT(MDT), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model: what the pipeline is doing, not how the RTL encodes it.
  bit m_busy_md;    // a mul/div is occupying EX
  int m_md_cycles;  // cycles the mul/div has spent in EX so far
  bit m_done_seen;  // completion arrived while memory held everything
  bit m_to;
  int m_stalls;

  typedef enum int {K_NONE, K_FREEZE, K_MDHOLD, K_FLUSH, K_BUBBLE} kind_t;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(int rs1, int rs2, int rd, bit dmrd, bit br, bit mds,
                       bit mdd, bit req, bit rdy);
    bus.de_rs1 = 5'(rs1);  bus.de_rs2 = 5'(rs2);  bus.ex_rd = 5'(rd);
    bus.ex_dmrd = dmrd;  bus.ex_br_taken = br;  bus.ex_md_start = mds;
    bus.md_done = mdd;  bus.me_dm_req = req;  bus.dm_ready = rdy;
  endtask

  task automatic model_reset();
    m_busy_md = 0;  m_md_cycles = 0;  m_done_seen = 0;  m_to = 0;  m_stalls = 0;
  endtask

  // Called at negedge with inputs applied; returns at the next negedge.
  task automatic cyc(string tag);
    kind_t k;
    logic [7:0] e, o;
    bit lu;
    #1;
    if (!rst_n) model_reset();
    lu = bus.ex_dmrd && bus.ex_rd != 0 &&
         (bus.ex_rd == bus.de_rs1 || bus.ex_rd == bus.de_rs2);
    if (!rst_n)                               k = K_NONE;
    else if (bus.me_dm_req && !bus.dm_ready)  k = K_FREEZE;
    else if (m_busy_md)
      k = (bus.md_done || m_done_seen || m_md_cycles >= MDT - 1) ? K_NONE : K_MDHOLD;
    else if (bus.ex_md_start)                 k = K_MDHOLD;
    else if (bus.ex_br_taken)                 k = K_FLUSH;
    else if (lu)                              k = K_BUBBLE;
    else                                      k = K_NONE;
    // {pc_en, fd_en, fd_clr, de_en, de_clr, em_en, em_clr, mw_clr}
    case (k)
      K_FREEZE: e = 8'b0_0_0_0_0_0_0_1;
      K_MDHOLD: e = 8'b0_0_0_0_0_1_1_0;
      K_FLUSH:  e = 8'b1_1_1_1_1_1_0_0;
      K_BUBBLE: e = 8'b0_0_0_1_1_1_0_0;
      default:  e = 8'b1_1_0_1_0_1_0_0;
    endcase
    o = {bus.pc_enable, bus.fd_enable, bus.fd_clr, bus.de_enable, bus.de_clr,
         bus.em_enable, bus.em_clr, bus.mw_clr};
    chk({tag, ".ctrl"}, 32'(o), 32'(e));
    chk({tag, ".to"},   32'(bus.md_timeout), 32'(m_to));
    chk({tag, ".cnt"},  32'(bus.stall_cycles), 32'(m_stalls));
    @(posedge clk);
    if (rst_n) begin
      if (!e[7] && m_stalls < (1 << CW) - 1) m_stalls++;
      if (k == K_FREEZE) begin
        if (bus.md_done) m_done_seen = 1;
      end else if (m_busy_md) begin
        if (k == K_NONE) begin
          if (!(bus.md_done || m_done_seen)) m_to = 1;
          m_busy_md = 0;  m_md_cycles = 0;  m_done_seen = 0;
        end else m_md_cycles++;
      end else if (k == K_MDHOLD) begin
        m_busy_md = 1;  m_md_cycles = 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("rst");
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    // Reset with hostile inputs still yields pass-through outputs.
    drive(5, 5, 5, 1, 1, 1, 1, 1, 0);
    cyc("rst_hostile");
    rst_n = 1'b1;

    // Load-use: one bubble, then defaults.
    drive(0, 5, 5, 1, 0, 0, 0, 0, 0);  cyc("lu");
    drive(0, 5, 5, 0, 0, 0, 0, 0, 0);  cyc("lu_after");
    chk("lu_cnt", 32'(bus.stall_cycles), 32'd1);

    // x0 never stalls; branch overrides a load-use match.
    drive(0, 3, 0, 1, 0, 0, 0, 0, 0);  cyc("x0");
    drive(0, 5, 5, 1, 1, 0, 0, 0, 0);  cyc("br");
    chk("br_pc", 32'(bus.pc_enable), 32'd1);

    // Mul/div with done at cycle 4.
    do_reset();
    for (int i = 0; i < 4; i++) begin drive(0, 0, 0, 0, 0, 1, 0, 0, 0); cyc("md_hold"); end
    drive(0, 0, 0, 0, 0, 1, 1, 0, 0);  cyc("md_rel");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);  cyc("md_run");
    chk("md_cnt", 32'(bus.stall_cycles), 32'd4);
    chk("md_to0", 32'(bus.md_timeout), 32'd0);

    // Timeout with ex_md_start held and no done.
    do_reset();
    for (int i = 0; i < MDT; i++) begin drive(0, 0, 0, 0, 0, 1, 0, 0, 0); cyc("to_wait"); end
    chk("to_set", 32'(bus.md_timeout), 32'd1);
    for (int i = 0; i < 3; i++) begin drive(0, 0, 0, 0, 0, 0, 0, 0, 0); cyc("to_sticky"); end
    chk("to_stay", 32'(bus.md_timeout), 32'd1);

    // Memory freeze overlapping MD_WAIT, done pulsed mid-freeze.
    do_reset();
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0);  cyc("ov_start");
    drive(0, 0, 0, 0, 0, 1, 0, 1, 0);  cyc("ov_fz1");
    drive(0, 0, 0, 0, 0, 1, 1, 1, 0);  cyc("ov_fz2");
    drive(0, 0, 0, 0, 0, 1, 0, 1, 0);  cyc("ov_fz3");
    drive(0, 0, 0, 0, 0, 1, 0, 1, 1);  cyc("ov_rel");
    chk("ov_em_en", 32'(bus.em_enable), 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);  cyc("ov_run");

    // Saturation at 2^CNT_W-1.
    do_reset();
    for (int i = 0; i < 20; i++) begin drive(7, 0, 7, 1, 0, 0, 0, 0, 0); cyc("sat"); end
    chk("sat_cnt", 32'(bus.stall_cycles), 32'd15);

    // Reset asserted mid-MD_WAIT during a freeze.
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0);  cyc("mr_start");
    drive(0, 0, 0, 0, 0, 1, 1, 1, 0);  cyc("mr_wait");
    #2 rst_n = 1'b0;
    #1 chk("mr_cnt", 32'(bus.stall_cycles), 32'd0);
    chk("mr_pc", 32'(bus.pc_enable), 32'd1);
    chk("mr_mwclr", 32'(bus.mw_clr), 32'd0);
    @(negedge clk);
    cyc("mr_held");
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);  cyc("mr_after");

    // Random traffic, small register space to make hazards frequent.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(99) < 2) rst_n = 1'b0;
      else rst_n = 1'b1;
      drive($urandom_range(3), $urandom_range(3), $urandom_range(3),
            $urandom_range(99) < 40, $urandom_range(99) < 15,
            $urandom_range(99) < 15, $urandom_range(99) < 10,
            $urandom_range(99) < 30, $urandom_range(99) < 60);
      cyc("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline (IF, ID, EX, MEM, WB).
- Arbitrates four sources and drives enable/clear for the PC and the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB):
  - load-use hazard
  - taken branch in EX
  - multi-cycle mul/div in EX
  - data-memory wait state
- Supersedes the standalone combinational load-use detector.

Parameters:
- MD_TIMEOUT, 64, max MD_WAIT cycles before forced release; must be >= 2.
- CNT_W, 16, width of the stall-cycle performance counter.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- de_rs1  input  5  ID-stage source register 1.
- de_rs2  input  5  ID-stage source register 2.
- ex_rd  input  5  EX-stage destination register.
- ex_dmrd  input  1  EX instruction is a load.
- ex_br_taken  input  1  EX branch/jump resolved taken.
- ex_md_start  input  1  EX holds a mul/div instruction.
- md_done  input  1  mul/div result valid, 1-cycle pulse.
- me_dm_req  input  1  MEM instruction accesses data memory.
- dm_ready  input  1  data memory completes access this cycle.
- pc_enable  output  1  PC update enable.
- fd_enable  output  1  IF/ID register enable.
- fd_clr  output  1  IF/ID flush, synchronous at next edge.
- de_enable  output  1  ID/EX register enable.
- de_clr  output  1  ID/EX flush, inserts bubble.
- em_enable  output  1  EX/MEM register enable.
- em_clr  output  1  EX/MEM flush.
- mw_clr  output  1  MEM/WB flush.
- md_timeout  output  1  sticky: MD_WAIT exited by timeout.
- stall_cycles  output  CNT_W  count of cycles with pc_enable=0, saturating.

Behaviour:
- Reset: asynchronous on rst_n low.
  - State RUN; md_cnt=0; md_done_q=0; md_timeout=0; stall_cycles=0.
  - While rst_n=0, all enables=1 and all clrs=0, regardless of inputs.
- Default outputs: all enables 1, all clrs 0. Clear takes precedence over enable at a register.
- States: RUN, MD_WAIT.
- Priority, highest first, evaluated each cycle:
  1. Memory freeze: me_dm_req=1 and dm_ready=0, in any state.
     - pc, fd, de, em enables all 0; mw_clr=1.
     - State, md_cnt and md_cnt-based timeout held.
     - md_done arriving now is latched into md_done_q.
  2. MD_WAIT:
     - pc/fd/de enables 0, em_clr=1.
     - md_cnt increments.
     - If md_done or md_done_q:
       - Release: defaults for this cycle, so EX advances.
       - md_done_q cleared; next state RUN; md_cnt cleared.
     - Else if md_cnt = MD_TIMEOUT-1:
       - Release identically, and set md_timeout=1 (sticky until reset).
  3. RUN, ex_md_start=1:
     - Same freeze as MD_WAIT; next state MD_WAIT; md_cnt=1.
     - ex_md_start is ignored while in MD_WAIT.
  4. RUN, ex_br_taken=1:
     - fd_clr=1, de_clr=1, pc_enable=1 (PC loads the target).
     - Suppresses load-use, because that ID instruction is on the wrong path.
  5. RUN, load-use:
     - Condition: ex_dmrd=1 and ex_rd != 0 and (ex_rd==de_rs1 or ex_rd==de_rs2).
     - pc_enable=0, fd_enable=0, de_clr=1.
     - Exactly one bubble; no state change.
     - ex_rd=0 never stalls.
- Latency: outputs are combinational from state and inputs within the same cycle. State updates on the rising edge.
- stall_cycles:
  - +1 on each edge where pc_enable=0 and rst_n=1.
  - Holds at 2^CNT_W-1.
- Reset asserted mid-MD_WAIT or mid-freeze: immediate return to reset values; no pending md_done_q survives.

Test Plan:
- Load-use: ex_dmrd=1, ex_rd=5, de_rs2=5 in RUN -> one cycle with pc_enable=0, fd_enable=0, de_clr=1; next cycle (ex_dmrd=0) all defaults; stall_cycles=1.
- x0 and branch: ex_dmrd=1, ex_rd=0, de_rs1=0 -> no stall. Then ex_br_taken=1 with a matching load-use pattern -> fd_clr=de_clr=1, pc_enable=1, fd_enable=1.
- Mul/div: ex_md_start at cycle 0, md_done at cycle 4 -> pc/fd/de enables 0 and em_clr=1 for cycles 0-3; defaults at cycle 4; state RUN at cycle 5; stall_cycles=4.
- Timeout: MD_TIMEOUT=8, ex_md_start held, no md_done -> release on the 8th MD_WAIT-frozen cycle; md_timeout=1 and stays 1 thereafter.
- Freeze overlap: in MD_WAIT, me_dm_req=1, dm_ready=0 for 3 cycles with md_done pulsed in the 2nd -> global freeze (mw_clr=1) for 3 cycles; release on the first cycle after dm_ready=1.
- Reset/saturation: CNT_W=4 with 20 stall cycles -> stall_cycles=15. Assert rst_n=0 mid-MD_WAIT -> outputs at reset values immediately, counter 0.
